wb_master_pwm_mc: RTL and testbench

WB_MASTER_PWM_MC -- requirements
Module: wb_master_pwm_mc

---
 rtl/wb_master_pwm_mc.sv | 238 +++++++++++++++++++++++
 tb/tb_wb_master_pwm_mc.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_master_pwm_mc.sv
// Write-only Wishbone master that initialises and feeds NCH PWM channels.
// Optional bus timeout: define WBM_TIMEOUT_EN.
module wb_master_pwm_mc #(
  parameter int          NCH       = 4,
  parameter int          CH_STRIDE = 16,
  parameter logic [31:0] CTRL_WORD = 32'h16,
  parameter int          TIMEOUT   = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  output logic [15:0]       wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  output logic              wbm_we_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic [32*NCH-1:0] period_input,
  input  logic [32*NCH-1:0] pid_output,
  input  logic [NCH-1:0]    pid_valid,
  output logic              init_done_o,
  output logic              err_o,
  input  logic              err_clr_i
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    INIT_PER, INIT_CTRL, SCAN, BUS, GAP
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   ch, ch_n;
  logic [CW-1:0]   rr_ptr, rr_n;
  logic [CW-1:0]   pick;
  logic            pick_ok;
  logic            cyc, cyc_n;
  logic [15:0]     adr, adr_n;
  logic [31:0]     dat, dat_n;
  logic            is_per, is_per_n;
  logic            done, done_n;
  logic            err, err_n;
  logic            tmo, ok, bad;

  logic [31:0]     per_in [NCH];
  logic [31:0]     pid_in [NCH];
  logic [31:0]     per_q  [NCH];
  logic [31:0]     duty_q [NCH];
  logic [NCH-1:0]  dpend, ppend;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign per_in[g] = period_input[32*g +: 32];
    assign pid_in[g] = pid_output[32*g +: 32];
  end

  function automatic logic [31:0] clamp(
    input logic [31:0] v,
    input logic [31:0] p
  );
    if (v[31]) return '0;
    if (v > p) return p;
    return v;
  endfunction

  function automatic logic [15:0] reg_adr(
    input int i,
    input int off
  );
    return 16'(i * CH_STRIDE + off);
  endfunction

`ifdef WBM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)  tcnt <= '0;
    else if (!cyc)   tcnt <= '0;
    else if (!tmo)   tcnt <= tcnt + 1'b1;
  end

  assign tmo = cyc && (tcnt == TW'(TIMEOUT - 1));
`else
  // No counter: the comparison is constant-false for any legal TIMEOUT.
  assign tmo = cyc && (TIMEOUT < 0);
`endif

  assign ok  = cyc & wbm_ack_i;
  assign bad = cyc & ~wbm_ack_i & (wbm_err_i | tmo);

  always_comb begin
    int j;
    j       = 0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (!pick_ok && (ppend[j] || dpend[j])) begin
        pick    = CW'(j);
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    ch_n     = ch;
    rr_n     = rr_ptr;
    cyc_n    = cyc;
    adr_n    = adr;
    dat_n    = dat;
    is_per_n = is_per;
    done_n   = done;
    err_n    = bad | (err & ~err_clr_i);
    unique case (state)
      INIT_PER: begin
        if (!cyc) begin
          cyc_n = 1'b1;
          adr_n = reg_adr(int'(ch), 4);
          dat_n = per_in[ch];
        end else if (ok) begin
          cyc_n   = 1'b0;
          state_n = INIT_CTRL;
        end else if (bad) begin
          cyc_n = 1'b0;
        end
      end
      INIT_CTRL: begin
        if (!cyc) begin
          cyc_n = 1'b1;
          adr_n = reg_adr(int'(ch), 0);
          dat_n = CTRL_WORD;
        end else if (ok) begin
          cyc_n = 1'b0;
          if (ch == CW'(NCH - 1)) begin
            state_n = SCAN;
            done_n  = 1'b1;
          end else begin
            ch_n    = ch + 1'b1;
            state_n = INIT_PER;
          end
        end else if (bad) begin
          cyc_n = 1'b0;
        end
      end
      SCAN: begin
        if (pick_ok) begin
          state_n = BUS;
          cyc_n   = 1'b1;
          ch_n    = pick;
          if (ppend[pick]) begin
            adr_n    = reg_adr(int'(pick), 4);
            dat_n    = per_in[pick];
            is_per_n = 1'b1;
          end else begin
            adr_n    = reg_adr(int'(pick), 6);
            dat_n    = duty_q[pick];
            is_per_n = 1'b0;
          end
        end
      end
      BUS: begin
        if (ok) begin
          cyc_n   = 1'b0;
          state_n = GAP;
          rr_n    = (ch == CW'(NCH - 1)) ? '0 : ch + 1'b1;
        end else if (bad) begin
          cyc_n   = 1'b0;
          state_n = GAP;
        end
      end
      GAP:     state_n = SCAN;
      default: state_n = INIT_PER;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state  <= INIT_PER;
      ch     <= '0;
      rr_ptr <= '0;
      cyc    <= 1'b0;
      adr    <= '0;
      dat    <= '0;
      is_per <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      ch     <= ch_n;
      rr_ptr <= rr_n;
      cyc    <= cyc_n;
      adr    <= adr_n;
      dat    <= dat_n;
      is_per <= is_per_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

  // A duty value captured while its write was in flight keeps dpend set.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < NCH; i++) begin
        per_q[i]  <= '0;
        duty_q[i] <= '0;
      end
      dpend <= '0;
      ppend <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (pid_valid[i])
          duty_q[i] <= clamp(pid_in[i], per_in[i]);
        if (ok && ch == CW'(i) &&
            (state == INIT_PER || (state == BUS && is_per)))
          per_q[i] <= dat;
        if (ok && state == BUS && ch == CW'(i) && !is_per &&
            !pid_valid[i] && duty_q[i] == dat)
          dpend[i] <= 1'b0;
        else if (pid_valid[i])
          dpend[i] <= 1'b1;
        if (ok && state == BUS && ch == CW'(i) && is_per)
          ppend[i] <= 1'b0;
        else if (done && per_in[i] != per_q[i])
          ppend[i] <= 1'b1;
      end
    end
  end

  assign wbm_adr_o   = adr;
  assign wbm_dat_o   = dat;
  assign wbm_cyc_o   = cyc;
  assign wbm_stb_o   = cyc;
  assign wbm_we_o    = cyc;
  assign init_done_o = done;
  assign err_o       = err;

endmodule

// File: tb/tb_wb_master_pwm_mc.sv
// Directed bench for wb_master_pwm_mc: init order, clamp, arbitration,
// error retry and reset; timeout path when WBM_TIMEOUT_EN is defined.
module tb_wb_master_pwm_mc;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       adr;
  logic [31:0]       dat;
  logic              we, cyc, stb;
  logic              ack = 1'b0;
  logic              berr = 1'b0;
  logic [32*NCH-1:0] period_input = '0;
  logic [32*NCH-1:0] pid_output = '0;
  logic [NCH-1:0]    pid_valid = '0;
  logic              init_done, err_o;
  logic              err_clr = 1'b0;

  int total  = 0;
  int passed = 0;

  wb_master_pwm_mc #(
    .NCH(NCH), .CH_STRIDE(16), .CTRL_WORD(32'h16), .TIMEOUT(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm_adr_o(adr), .wbm_dat_o(dat),
    .wbm_we_o(we), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
    .wbm_ack_i(ack), .wbm_err_i(berr),
    .period_input(period_input), .pid_output(pid_output),
    .pid_valid(pid_valid), .init_done_o(init_done),
    .err_o(err_o), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(output bit got);
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = cyc;
    end
  endtask

  task automatic pulse(input int c, input logic [31:0] v);
    pid_output[32*c +: 32] = v;
    pid_valid[c] = 1'b1;
    @(negedge clk);
    pid_valid = '0;
  endtask

  // One write: check launch, hold for a cycle, then ack (or err).
  task automatic xfer(input string tag, input logic [15:0] ea,
                      input logic [31:0] ed, input bit e = 1'b0,
                      input bit clr = 1'b0, input int cch = -1,
                      input logic [31:0] cval = '0);
    bit got;
    wait_cyc(got);
    chk({tag, "_wait"}, 64'(got), 64'd1);
    if (!got) return;
    chk({tag, "_adr"}, 64'(adr), 64'(ea));
    chk({tag, "_dat"}, 64'(dat), 64'(ed));
    chk({tag, "_we_stb"}, 64'({we, stb}), 64'd3);
    @(negedge clk);
    chk({tag, "_hold"}, 64'({cyc, stb, we, adr, dat}),
        64'({3'b111, ea, ed}));
    if (e) berr = 1'b1;
    else ack = 1'b1;
    if (clr) err_clr = 1'b1;
    if (cch >= 0) begin
      pid_output[32*cch +: 32] = cval;
      pid_valid[cch] = 1'b1;
    end
    @(negedge clk);
    ack = 1'b0;
    berr = 1'b0;
    err_clr = 1'b0;
    pid_valid = '0;
    chk({tag, "_idle"}, 64'(cyc), 64'd0);
  endtask

  task automatic init_seq(input string tag, input logic [31:0] p2);
    xfer({tag, "_p0"}, 16'h04, 32'd100);
    xfer({tag, "_c0"}, 16'h00, 32'h16);
    xfer({tag, "_p1"}, 16'h14, 32'd200);
    xfer({tag, "_c1"}, 16'h10, 32'h16);
    xfer({tag, "_p2"}, 16'h24, p2);
    xfer({tag, "_c2"}, 16'h20, 32'h16);
    xfer({tag, "_p3"}, 16'h34, 32'd400);
    chk({tag, "_done_lo"}, 64'(init_done), 64'd0);
    xfer({tag, "_c3"}, 16'h30, 32'h16);
    chk({tag, "_done_hi"}, 64'(init_done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bit got;
    int n;
    period_input = {32'd400, 32'd300, 32'd200, 32'd100};
    repeat (2) @(negedge clk);
    chk("rst_bus", 64'({cyc, stb, we, adr, dat}), 64'd0);
    chk("rst_flags", 64'({init_done, err_o}), 64'd0);
    rst_n = 1'b1;

    init_seq("init", 32'd300);
    repeat (3) @(negedge clk);
    chk("idle_scan", 64'(cyc), 64'd0);

    // Three channels at once, round-robin from channel 0; ch3 clamps.
    pid_output[31:0]   = 32'd50;
    pid_output[95:64]  = 32'd120;
    pid_valid = 4'b1101;
    pid_output[127:96] = 32'd500;
    @(negedge clk);
    pid_valid = '0;
    xfer("rr_ch0", 16'h06, 32'd50);
    xfer("rr_ch2", 16'h26, 32'd120);
    xfer("rr_ch3", 16'h36, 32'd400);

    period_input[95:64] = 32'd350;
    pulse(2, 32'd77);
    xfer("per_first", 16'h24, 32'd350);
    xfer("duty_after", 16'h26, 32'd77);

    pulse(1, 32'd250);
    xfer("clamp_hi", 16'h16, 32'd200);
    pulse(1, 32'hFFFF_FFF0);
    xfer("clamp_neg", 16'h16, 32'd0);

    // Second ch1 value arrives before ch1 is served: only latest written.
    pid_output[31:0]  = 32'd5;
    pid_output[63:32] = 32'd10;
    pid_valid = 4'b0011;
    @(negedge clk);
    pulse(1, 32'd20);
    xfer("latest_ch0", 16'h06, 32'd5);
    xfer("latest_ch1", 16'h16, 32'd20);

    pulse(0, 32'd30);
    xfer("co_first", 16'h06, 32'd30, 1'b0, 1'b0, 0, 32'd60);
    xfer("co_second", 16'h06, 32'd60);

    pulse(3, 32'd123);
    xfer("err_try", 16'h36, 32'd123, 1'b1);
    chk("err_set", 64'(err_o), 64'd1);
    xfer("err_retry", 16'h36, 32'd123);
    chk("err_sticky", 64'(err_o), 64'd1);
    pulse(3, 32'd9);
    xfer("err_clr_try", 16'h36, 32'd9, 1'b1, 1'b1);
    chk("err_wins", 64'(err_o), 64'd1);
    xfer("err_clr_retry", 16'h36, 32'd9);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 64'(err_o), 64'd0);

    pulse(2, 32'd44);
    wait_cyc(got);
    chk("rst_bus_wait", 64'(got), 64'd1);
    chk("rst_bus_adr", 64'(adr), 64'h26);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 64'({cyc, stb, we, init_done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    init_seq("reinit", 32'd350);
    repeat (3) @(negedge clk);
    chk("reinit_idle", 64'({cyc, err_o}), 64'd0);

`ifdef WBM_TIMEOUT_EN
    pulse(0, 32'd7);
    wait_cyc(got);
    chk("tmo_wait", 64'(got), 64'd1);
    n = 0;
    while (cyc && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", 64'(n), 64'd8);
    chk("tmo_err", 64'(err_o), 64'd1);
`else
    n = 0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
